// File: rtl/add_seq_if.sv
// Operand/result bundle for the sliced adder: master issues start/sub/a/b, slave returns status and flags.
// Pure wiring, no latency; no backpressure beyond busy (start is ignored while busy).
interface add_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry, overflow, zero
    );
endinterface

// File: rtl/add_seq.sv
// Multi-cycle add/sub, SLICE bits per clock; done pulses N+1 cycles after start is accepted.
// start is only taken in IDLE or DONE; a start while busy is dropped, giving one op per N+1 cycles.
module add_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic     clk,
    input  logic     rst,
    add_seq_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cin_q, cin_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [BW-1:0]    base;
    logic [SLICE:0]   slice_sum;

    always_comb begin
        base      = BW'(int'(idx_q) * SLICE);
        slice_sum = {1'b0, opa_q[base +: SLICE]} + {1'b0, opb_q[base +: SLICE]}
                  + (SLICE + 1)'(cin_q);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cin_d    = cin_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: invert B once here, seed the chain with 1.
                    opa_d   = bus.a;
                    opb_d   = bus.b ^ {WIDTH{bus.sub}};
                    cin_d   = bus.sub;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d[base +: SLICE] = slice_sum[SLICE-1:0];
                cin_d                = slice_sum[SLICE];
                if (idx_q == LAST) begin
                    result_d = acc_d;
                    carry_d  = slice_sum[SLICE];
                    ovf_d    = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                               (acc_d[WIDTH-1] != opa_q[WIDTH-1]);
                    zero_d   = (acc_d == '0);
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cin_q    <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cin_q    <= cin_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_add_seq.sv
// Bench for add_seq at SLICE = 8, 32 and 1 (WIDTH = 32): scoreboard queues per instance,
// expectations from a plain-arithmetic reference model or from literal vectors.
module tb_add_seq;
    localparam int NS = 3;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        exp_t        e;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NS-1:0]   start_v = '0;
    logic [NS-1:0]   busy_v;
    logic [NS-1:0]   done_v;
    logic [31:0]     a_s = '0;
    logic [31:0]     b_s = '0;
    logic            sub_s = 1'b0;
    exp_t            q [NS][$];
    int              checks = 0;
    int              errors = 0;
    longint          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (inst %0d): got %h expected %h at cycle %0d", nm, g, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint sa, sb, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            e.res = a - b;
            e.c   = (a >= b);
            sr    = sa - sb;
        end else begin
            e.res = a + b;
            e.c   = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
            sr    = sa + sb;
        end
        e.o = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    for (genvar g = 0; g < NS; g++) begin : gd
        localparam int SL = (g == 0) ? 8 : ((g == 1) ? 32 : 1);
        localparam int NN = 32 / SL;

        add_seq_if #(.WIDTH(32)) bus ();

        add_seq #(.WIDTH(32), .SLICE(SL)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.start = start_v[g];
        assign bus.sub   = sub_s;
        assign bus.a     = a_s;
        assign bus.b     = b_s;
        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;

        int          busy_cnt = 0;
        logic [31:0] last_res = '0;
        logic        prev_done = 1'b0;

        always @(negedge clk) begin
            if (rst) begin
                busy_cnt  <= 0;
                last_res  <= '0;
                prev_done <= 1'b0;
            end else begin
                if (bus.done) begin
                    chk("done_pulse", g, 32'(prev_done), 32'd0);
                    chk("busy_len", g, 32'(busy_cnt), 32'(NN));
                    if (q[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done (inst %0d): got done=1 expected no pending op", g);
                    end else begin
                        chk("result", g, bus.result, q[g][0].res);
                        chk("carry", g, 32'(bus.carry), 32'(q[g][0].c));
                        chk("overflow", g, 32'(bus.overflow), 32'(q[g][0].o));
                        chk("zero", g, 32'(bus.zero), 32'(q[g][0].z));
                        last_res <= q[g][0].res;
                        q[g].delete(0);
                    end
                    busy_cnt <= 0;
                end else begin
                    chk("result_hold", g, bus.result, last_res);
                    if (bus.busy) busy_cnt <= busy_cnt + 1;
                end
                prev_done <= bus.done;
            end
        end
    end

    // Caller must be positioned just after a falling edge.
    task automatic issue(input int g, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input exp_t e);
        int n = 0;
        while (busy_v[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_v[g]) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout (inst %0d): busy=1 expected idle within 200 cycles", g);
        end else begin
            a_s        = a;
            b_s        = b;
            sub_s      = s;
            start_v[g] = 1'b1;
            q[g].push_back(e);
            @(negedge clk);
            start_v[g] = 1'b0;
        end
    endtask

    task automatic wait_done(input int g, output longint t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_v[g] && n < 100);
        if (!done_v[g]) begin
            checks++;
            errors++;
            $display("FAIL done_timeout (inst %0d): done=0 expected 1 within 100 cycles", g);
        end
        t = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy_v != '0 || q[0].size() + q[1].size() + q[2].size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending ops expected 0", q[0].size() + q[1].size() + q[2].size());
        end
    endtask

    vec_t   dir [6];
    longint t1, t2;
    logic [31:0] ra, rb;
    logic        rs;

    initial begin
        dir[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, '{32'h0000_0100, 1'b0, 1'b0, 1'b0}};
        dir[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        dir[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        dir[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        dir[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
        dir[5] = '{32'h0000_0005, 32'h0000_0005, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};

        // Two reset edges; start is high on the second, reset must win.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        chk("rst_busy", 0, 32'(gd[0].bus.busy), 32'd0);
        chk("rst_done", 0, 32'(gd[0].bus.done), 32'd0);
        chk("rst_result", 0, gd[0].bus.result, 32'd0);
        chk("rst_carry", 0, 32'(gd[0].bus.carry), 32'd0);
        chk("rst_overflow", 0, 32'(gd[0].bus.overflow), 32'd0);
        chk("rst_zero", 0, 32'(gd[0].bus.zero), 32'd0);
        start_v[0] = 1'b0;
        rst        = 1'b0;
        @(negedge clk);

        foreach (dir[i]) issue(0, dir[i].a, dir[i].b, dir[i].s, dir[i].e);
        drain();

        // A second start during RUN must not disturb the accepted op.
        issue(0, 32'h0000_1234, 32'h0000_0F00, 1'b0, '{32'h0000_2134, 1'b0, 1'b0, 1'b0});
        a_s        = 32'hFFFF_0000;
        b_s        = 32'h1234_5678;
        sub_s      = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        drain();

        // Start in the DONE cycle: next done is exactly N+1 cycles later.
        issue(0, 32'h0000_0010, 32'h0000_0020, 1'b0, model(32'h10, 32'h20, 1'b0));
        wait_done(0, t1);
        issue(0, 32'h0000_0003, 32'h0000_0009, 1'b1, model(32'h3, 32'h9, 1'b1));
        wait_done(0, t2);
        chk("b2b_gap", 0, 32'(t2 - t1), 32'd5);
        drain();

        for (int i = 0; i < 40; i++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) @(negedge clk);
            ra = pick();
            rb = pick();
            rs = 1'($urandom_range(0, 1));
            issue(0, ra, rb, rs, model(ra, rb, rs));
        end
        drain();

        issue(0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, model(32'h0F0F_0F0F, 32'h0101_0101, 1'b0));
        drain();

        // Reset in the second RUN cycle discards the op with no done.
        a_s        = 32'hDEAD_BEEF;
        b_s        = 32'h0000_0001;
        sub_s      = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("busy_before_rst", 0, 32'(gd[0].bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 0, 32'(gd[0].bus.busy), 32'd0);
        chk("midrst_done", 0, 32'(gd[0].bus.done), 32'd0);
        chk("midrst_result", 0, gd[0].bus.result, 32'd0);
        chk("midrst_flags", 0, {29'd0, gd[0].bus.carry, gd[0].bus.overflow, gd[0].bus.zero}, 32'd0);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int g = 1; g < NS; g++) begin
            issue(g, dir[0].a, dir[0].b, dir[0].s, dir[0].e);
            for (int i = 0; i < 10; i++) begin
                ra = pick();
                rb = pick();
                rs = 1'($urandom_range(0, 1));
                issue(g, ra, rb, rs, model(ra, rb, rs));
            end
        end
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/add_seq.md
# add_seq

Parametrised multi-cycle adder/subtractor for the single-cycle CPU datapath. It is the successor to the fixed 32-bit combinational adder. It splits a WIDTH-bit add or subtract into WIDTH/SLICE carry-chained slices, processing one slice per clock. It uses a start/busy/done handshake and produces carry, signed-overflow and zero flags. Used where a short per-cycle carry chain matters more than latency, and as the adder core of a future multi-cycle ALU.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 8, bits added per clock; 1 ≤ SLICE ≤ WIDTH. N = WIDTH/SLICE.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when not busy.
- sub  input  1  0 = a + b, 1 = a − b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result and flags are valid and newly updated.
- result  output  WIDTH  last completed sum/difference.
- carry  output  1  carry out of MSB of last op (for sub: 1 = no borrow).
- overflow  output  1  signed overflow of last op.
- zero  output  1  result == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - latch a into opA, b ^ {WIDTH{sub}} into opB, cin = sub.
  - clear slice index idx = 0, clear accumulator.
  - go to RUN.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- RUN, each cycle:
  - {c, s} = opA[idx slice] + opB[idx slice] + cin (SLICE+1 bits).
  - write s into accumulator slice idx; cin ← c; idx ← idx+1.
- RUN, slice idx = N−1: in the same edge, load result ← full accumulator, carry ← final c, overflow ← (a_msb == opB_msb) && (sum_msb != a_msb), zero ← (full sum == 0); go to DONE.
- The slice index counts 0..N−1 and never wraps. idx width = max(1, clog2(N)).
- result and flags change only on the completing edge. They hold their values through IDLE and through later RUN phases until the next completion.
- start while busy (RUN) is ignored. Operands are not re-sampled and no error is flagged.
- start in the DONE cycle is accepted, giving back-to-back operations with no idle bubble.
- Arithmetic is modulo 2^WIDTH. Unsigned and signed interpretations are reported through carry and overflow respectively.

## Timing
- Reset (rst=1 at an edge, in any state including mid-RUN): go to IDLE; idx=0; accumulator, result, carry, overflow, zero all 0; busy=0, done=0. The in-flight operation is discarded and produces no done.
- rst has priority over start in the same cycle.
- busy = (state == RUN): high for exactly N cycles after the edge that accepts start.
- done = (state == DONE): high for exactly 1 cycle.
- Latency: if start is accepted at edge k, done is high in the cycle after edge k+N. For N=1 (SLICE=WIDTH), done is high two edges after acceptance.
- Throughput: one operation per N+1 cycles with back-to-back starts.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
Default WIDTH=32, SLICE=8 unless noted.
- Reset: hold rst for 2 cycles → busy=0, done=0, result=0x00000000, carry=overflow=zero=0.
- Carry across slices: add 0x000000FF + 0x00000001 → busy for 4 cycles, then done pulse; result=0x00000100, carry=0, overflow=0, zero=0.
- Wrap and zero: add 0xFFFFFFFF + 0x00000001 → result=0x00000000, carry=1, zero=1, overflow=0. Signed overflow: add 0x7FFFFFFF + 0x00000001 → result=0x80000000, overflow=1, carry=0.
- Subtract: 0x80000000 − 0x00000001 → result=0x7FFFFFFF, overflow=1, carry=1. 5 − 7 → result=0xFFFFFFFE, carry=0, overflow=0.
- Handshake: start pulse during RUN with other operands → ignored, first result is unchanged. Start asserted in the DONE cycle → new op accepted; its done arrives 5 cycles after the previous done. result is stable between the two completions.
- Reset mid-op: assert rst in the 2nd RUN cycle → next cycle IDLE, all outputs 0, no done pulse. Repeat test 2 with SLICE=32 (busy 1 cycle) and SLICE=1 (busy 32 cycles) → same result and flags.
